stim_burst_gen: RTL and testbench



---
 rtl/stim_burst_gen.sv | 82 ++++++++
 tb/tb_stim_burst_gen.sv | 113 +++++++++++
 2 files changed

// File: rtl/stim_burst_gen.sv
// stim_burst_gen: start-triggered burst of count/LFSR beats on a valid/ready stream, with a done pulse.
// Optional STIM_BURST_PARITY_EN adds a registered even-parity output out_parity.
module stim_burst_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [LEN_W-1:0] len,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
`ifdef STIM_BURST_PARITY_EN
  output logic             out_parity,
`endif
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [WIDTH-1:0] D_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] L_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  state_t state, state_n;
  logic [WIDTH-1:0] data_n, lfsr;
  logic [LEN_W-1:0] cnt, cnt_n, len_q, len_n;
  logic mode_q, mode_n, hs, last;
  assign hs = out_valid & out_ready;
  assign last = cnt == len_q - L_ONE;
  assign lfsr = {out_data[WIDTH-2:0], out_data[WIDTH-1] ^ out_data[WIDTH-3] ^ out_data[WIDTH-4] ^ out_data[WIDTH-5]};
  always_comb begin
    state_n = state;
    data_n = out_data;
    cnt_n = cnt;
    mode_n = mode_q;
    len_n = len_q;
    unique case (state)
      IDLE: if (start) begin
        mode_n = mode;
        len_n = len;
        cnt_n = '0;
        data_n = (mode && seed == '0) ? D_ONE : seed;
        state_n = (len == '0) ? DONE : RUN;
      end
      RUN: if (hs) begin
        state_n = last ? DONE : RUN;
        cnt_n = last ? cnt : cnt + L_ONE;
        data_n = last ? out_data : (mode_q ? lfsr : out_data + D_ONE);
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      out_data <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      mode_q <= 1'b0;
      len_q <= '0;
    end else begin
      state <= state_n;
      out_data <= data_n;
      out_valid <= state_n == RUN;
      busy <= state_n == RUN;
      done <= state_n == DONE;
      cnt <= cnt_n;
      mode_q <= mode_n;
      len_q <= len_n;
    end
  end
`ifdef STIM_BURST_PARITY_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) out_parity <= 1'b0;
    else out_parity <= ^data_n;
  end
`endif
endmodule

// File: tb/tb_stim_burst_gen.sv
// tb_stim_burst_gen: directed and randomized bursts checked against a queue-based beat model.
module tb_stim_burst_gen;
  logic clk = 0, resetn = 1, start = 0, mode = 0, out_ready = 0;
  logic [7:0] seed = 0, out_data;
  logic [3:0] len = 0;
  logic out_valid, busy, done;
`ifdef STIM_BURST_PARITY_EN
  logic out_parity;
`endif
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  stim_burst_gen #(.WIDTH(8), .LEN_W(4)) dut (
    .clk(clk), .resetn(resetn), .start(start), .mode(mode), .seed(seed), .len(len),
    .out_data(out_data), .out_valid(out_valid),
`ifdef STIM_BURST_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_ready(out_ready), .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] next_beat(input logic m, input logic [7:0] d);
    logic fb;
    fb = d[7] ^ d[5] ^ d[4] ^ d[3];
    return m ? 8'((d * 2) % 256 + fb) : 8'((d + 1) % 256);
  endfunction
  task automatic idle_chk(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask
  // rmode: 0 = always ready, 1 = random ready, 2 = stall the first three cycles
  task automatic burst(input logic m, input logic [7:0] s, input logic [3:0] l, input int rmode);
    logic [7:0] exp_q[$];
    logic [7:0] v;
    int beats = 0, cyc = 0;
    logic rdy;
    v = (m && s == 0) ? 8'h01 : s;
    for (int i = 0; i < int'(l); i++) begin
      exp_q.push_back(v);
      v = next_beat(m, v);
    end
    start = 1; mode = m; seed = s; len = l; out_ready = 0;
    step;
    start = 0; mode = 1'($urandom); seed = 8'($urandom); len = 4'($urandom);
    if (l != 0) begin
      while (beats < int'(l) && cyc < 400) begin
        chk("run_valid", 32'(out_valid), 1);
        chk("run_busy", 32'(busy), 1);
        chk("run_done", 32'(done), 0);
        chk("beat_data", 32'(out_data), 32'(exp_q[beats]));
`ifdef STIM_BURST_PARITY_EN
        chk("beat_parity", 32'(out_parity), 32'(^exp_q[beats]));
`endif
        rdy = rmode == 0 ? 1'b1 : rmode == 2 ? 1'(cyc >= 3) : 1'($urandom);
        out_ready = rdy; start = 1'($urandom); seed = 8'($urandom);
        step;
        cyc++;
        if (rdy) beats++;
      end
      chk("beat_count", 32'(beats), 32'(l));
      start = 0; out_ready = 1'($urandom);
    end
    chk("end_valid", 32'(out_valid), 0);
    chk("end_busy", 32'(busy), 0);
    chk("end_done", 32'(done), 1);
    step;
    idle_chk("idle_after");
  endtask
  initial begin
    #1 resetn = 0;
    #1;
    idle_chk("reset");
    chk("reset_data", 32'(out_data), 0);
    #2 resetn = 1;
    step;
    idle_chk("post_reset");
    burst(1'b0, 8'hFE, 4'd4, 0);
    burst(1'b1, 8'h01, 4'd5, 0);
    burst(1'b0, 8'h10, 4'd3, 2);
    burst(1'b0, 8'h33, 4'd0, 0);
    burst(1'b1, 8'h00, 4'd2, 0);
    burst(1'b0, 8'hFF, 4'd15, 1);
    start = 1; mode = 0; seed = 8'($urandom); len = 4'd6;
    step;
    start = 0; out_ready = 1;
    step;
    step;
    chk("mid_valid", 32'(out_valid), 1);
    #2 resetn = 0;
    #1;
    idle_chk("mid_reset");
    #1 resetn = 1; out_ready = 0;
    repeat (3) begin
      step;
      idle_chk("after_reset");
    end
    burst(1'b0, 8'h40, 4'd3, 1);
    repeat (30) burst(1'($urandom), 8'($urandom), 4'($urandom), 1);
    repeat (4) burst(1'b1, 8'h00, 4'($urandom_range(1, 15)), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
